csr_file: RTL and testbench
===========================

# csr_file

Machine-mode CSR file for the multicycle RV32 core. It replaces the single-mode CSR block and adds:
- interrupt enable/pending CSRs with a parametrised number of platform-local interrupt lines;
- synchronised interrupt inputs with fixed-priority cause selection;
- vectored `mtvec`;
- optional 64-bit cycle/instret counters.

It sits beside the control FSM, which consumes `irq_pending`, `irq_cause` and `trap_vector` and drives `trap_start`/`trap_finish`.

## Interface
Parameters:
- `NUM_LOCAL_IRQ`, 4: local interrupt lines, 0..16, mapped to `mip`/`mie` bits 16+i.
- `SYNC_STAGES`, 2: flops in each interrupt-input synchroniser, ≥1.
- `VECTORED_EN`, 1: 1 allows `mtvec` MODE=01.
- `HART_ID`, 0: value returned by `mhartid`.

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `csr_write` in 1: commit CSR write this cycle.
- `csr_op` in 2: WRITE/SET/CLEAR from `defs.svh`; any other value acts as WRITE.
- `csr_addr` in 12: CSR address for read and write.
- `csr_wr_data` in 32: operand.
- `csr_rd_data` out 32: combinational read data.
- `pc` in 32, `instruction` in 32, `misaligned_addr` in 32: trap info.
- `trap_start` in 1, `trap_finish` in 1, `trap_cause` in 32: trap entry/return.
- `instr_retire` in 1: one-cycle pulse per retired instruction.
- `irq_software` in 1, `irq_timer` in 1, `irq_external` in 1: asynchronous level inputs.
- `irq_local` in `NUM_LOCAL_IRQ`: asynchronous level inputs.
- `trap_vector` out 32: handler address.
- `interrupted_pc` out 32: current `mepc`.
- `irq_pending` out 1: a globally and individually enabled interrupt is pending.
- `irq_cause` out 32: cause of the highest-priority pending enabled interrupt.
- `interrupts_enabled` out 1: `mstatus.MIE`.

## Operation
- **Write data.** WRITE gives `d`. SET gives `rd | d`. CLEAR gives `rd & ~d`. Here `rd` is the current read value.
- **Read-only registers.** `mvendorid`, `marchid` and `mimpid` read 0; `mhartid` reads `HART_ID`. Writes to them are ignored.
- **Unimplemented addresses** read 0; writes to them are ignored.
- **Plain registers.** `misa` resets to 0x40000100. `mstatush` and `mscratch` reset to 0 and are fully writable.
- **`mstatus`.** On `trap_start`: MIE←0, MPIE←MIE, MPP←11. On `trap_finish`: MIE←MPIE, MPIE←0, MPP←00. `trap_start` wins over `trap_finish`; either wins over a CSR write in the same cycle.
- **`mepc`.** Set to `pc` on `trap_start`. CSR writes store `d[31:2]` with bits [1:0] forced to 00.
- **`mcause`.** Set to `trap_cause` on `trap_start`.
- **`mtval`.** On an exception `trap_start`:
  - ENV_BREAK → `pc`;
  - ILLEGAL_INST → `instruction`;
  - any misaligned cause → `misaligned_addr`;
  - other exception causes leave it unchanged.
  - An interrupt `trap_start` leaves it unchanged.
- **`mtvec`.** WARL.
  - MODE 10 or 11 keeps the previous MODE.
  - MODE 01 with `VECTORED_EN`=0 stores 00.
  - BASE is bits [31:2].
- **`trap_vector`.** Equals BASE for exceptions or MODE=00. For a vectored interrupt it is BASE + 4·code, where code is `irq_cause[4:0]`.
- **`mip`** (read-only, 0x344). Bits 3/7/11/16+i are the synchroniser outputs of software/timer/external/local. All other bits read 0.
- **`mie`** (0x304). Only bits 3, 7, 11 and 16..16+`NUM_LOCAL_IRQ`-1 are writable; all other bits read 0.
- **`irq_pending`** = MIE & |(`mip` & `mie`).
- **Priority.** MEI(11) > MSI(3) > MTI(7) > local, with the highest local index winning.
- **`irq_cause`** = {1, 26'b0, code}. It is 0 when nothing is enabled and pending.
- **Counters** (see Configuration):
  - `mcycle`/`mcycleh` at 0xB00/0xB80; `minstret`/`minstreth` at 0xB02/0xB82.
  - `mcountinhibit` (0x320): bit0 (CY) and bit2 (IR) are writable; other bits read 0.
  - `mcycle` increments every cycle unless CY=1. `minstret` increments on `instr_retire` unless IR=1.
  - A CSR write to either half replaces that half that cycle and suppresses that cycle's increment of the whole counter. It does not carry into the other half.
  - Counters wrap from 2^64−1 to 0.

## Timing
- **Reset.** All registers and synchroniser flops are cleared (`misa` = 0x40000100). Consequently `csr_rd_data` follows the addressed reset value, and `trap_vector`=0, `interrupted_pc`=0, `irq_pending`=0, `irq_cause`=0, `interrupts_enabled`=0.
- **Reset mid-operation** aborts any pending update immediately.
- **Reads** are combinational in the same cycle. **Writes** are visible after the next rising edge.
- **Interrupt latency.** An input level change reaches `mip` after exactly `SYNC_STAGES` rising edges. `irq_pending`/`irq_cause` follow combinationally from `mip`, `mie` and `mstatus`.
- **Deassertion** follows the same latency. Inputs are level-sensitive and nothing is latched.

## Configuration
- `CSR_COUNTERS_EN` defined: the counters and `mcountinhibit` are implemented as described.
- Not defined: 0xB00/0xB80/0xB02/0xB82/0x320 read 0, writes are ignored, no counter flops exist, and `instr_retire` is unused.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-write, then release. Required: `mstatus`=0, `misa` reads 0x40000100, `mhartid`=`HART_ID`, `irq_pending`=0.
- **Vectored interrupt.**
  - Stimulus: write `mtvec`=0x00001001, `mie`=0x800, `mstatus`=0x8, then raise `irq_external`.
  - Required: `irq_pending`=1 after exactly `SYNC_STAGES` edges, `irq_cause`=0x8000000B, `trap_vector`=0x0000102C.
  - Also write `mtvec` MODE=11: the previous MODE must be retained.
- **Priority.**
  - Stimulus: `mie`=0x00030888 with all inputs high.
  - Required: cause 11. Drop `irq_external` → cause 3; drop `irq_software` → 7; drop `irq_timer` → 0x80000011 (local 1).
- **Trap entry and return.**
  - Stimulus: `trap_start` with cause ILLEGAL_INST, `pc`=0x200, `instruction`=0xFFFFFFFF, with `mstatus`=0x8 beforehand.
  - Required after one edge: `mepc`=0x200, `mtval`=0xFFFFFFFF, `mstatus`=0x1880.
  - Then `trap_finish` → `mstatus`=0x0008.
- **Simultaneous events.** `trap_start` together with a `csr_write` to `mstatus` → the trap update wins. `trap_start` together with `trap_finish` → entry semantics apply.
- **Counters (`CSR_COUNTERS_EN`).**
  - Write `mcycle`=0xFFFFFFFF, `mcycleh`=0xFFFFFFFF. Required: reads 0 two edges later.
  - Set IR, pulse `instr_retire` 3 times → `minstret` unchanged. Clear IR, pulse 3 times → `minstret`=3.
  - Without the macro: all counter addresses read 0.

Source files
------------

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with synchronised irqs and vectored mtvec; counters only with CSR_COUNTERS_EN
// latency: reads combinational; writes/trap updates visible after next edge; irq inputs reach mip after SYNC_STAGES edges
// backpressure: none, every CSR write and trap request is taken in the cycle it is presented
module csr_file #(
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter int          SYNC_STAGES   = 2,
  parameter bit          VECTORED_EN   = 1'b1,
  parameter logic [31:0] HART_ID       = 32'd0
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         csr_write,
  input  logic [1:0]                                   csr_op,
  input  logic [11:0]                                  csr_addr,
  input  logic [31:0]                                  csr_wr_data,
  output logic [31:0]                                  csr_rd_data,
  input  logic [31:0]                                  pc,
  input  logic [31:0]                                  instruction,
  input  logic [31:0]                                  misaligned_addr,
  input  logic                                         trap_start,
  input  logic                                         trap_finish,
  input  logic [31:0]                                  trap_cause,
  input  logic                                         instr_retire,
  input  logic                                         irq_software,
  input  logic                                         irq_timer,
  input  logic                                         irq_external,
  input  logic [(NUM_LOCAL_IRQ > 0 ? NUM_LOCAL_IRQ : 1)-1:0] irq_local,
  output logic [31:0]                                  trap_vector,
  output logic [31:0]                                  interrupted_pc,
  output logic                                         irq_pending,
  output logic [31:0]                                  irq_cause,
  output logic                                         interrupts_enabled
);
  localparam int LW = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1;
  localparam int IW = 3 + LW;
  localparam logic [31:0] LOCAL_MASK = (NUM_LOCAL_IRQ == 0) ? 32'h0 :
                                       (((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << 16);
  localparam logic [31:0] MIE_MASK = 32'h0000_0888 | LOCAL_MASK;

  // csr_op: 10 = SET, 11 = CLEAR, anything else (01 WRITE, 00) replaces
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [31:0] CAUSE_INST_MISALIGN  = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL        = 32'd2;
  localparam logic [31:0] CAUSE_BREAK          = 32'd3;
  localparam logic [31:0] CAUSE_LOAD_MISALIGN  = 32'd4;
  localparam logic [31:0] CAUSE_STORE_MISALIGN = 32'd6;

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304;
  localparam logic [11:0] A_MTVEC = 12'h305, A_MSTATUSH = 12'h310, A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MTVAL = 12'h343;
  localparam logic [11:0] A_MIP = 12'h344, A_MHARTID = 12'hF14;

  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [1:0]  mst_mpp_q, mst_mpp_d;
  logic [31:0] misa_q, misa_d, mstatush_q, mstatush_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d, mie_q, mie_d;
  logic [29:0] mtvec_base_q, mtvec_base_d;
  logic [1:0]  mtvec_mode_q, mtvec_mode_d;
  logic [IW-1:0] sync_q [SYNC_STAGES];
  logic [IW-1:0] sync_d [SYNC_STAGES];
  logic [IW-1:0] irq_raw, irq_sync;
  logic [31:0] mip, irq_act, rd_data, wdata, mtvec_base;
  logic [4:0]  irq_code;

  assign irq_raw = {irq_local, irq_external, irq_timer, irq_software};

`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] A_MCYCLE = 12'hB00, A_MCYCLEH = 12'hB80;
  localparam logic [11:0] A_MINSTRET = 12'hB02, A_MINSTRETH = 12'hB82, A_MCOUNTINHIBIT = 12'h320;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic        cy_q, cy_d, ir_q, ir_d;

  // counter increment, half-replacement on CSR write, inhibit control
  always_comb begin
    mcycle_d   = mcycle_q;
    minstret_d = minstret_q;
    cy_d       = cy_q;
    ir_d       = ir_q;
    if (csr_write && csr_addr == A_MCYCLE)        mcycle_d[31:0]  = wdata;
    else if (csr_write && csr_addr == A_MCYCLEH)  mcycle_d[63:32] = wdata;
    else if (!cy_q)                               mcycle_d        = mcycle_q + 64'd1;
    if (csr_write && csr_addr == A_MINSTRET)      minstret_d[31:0]  = wdata;
    else if (csr_write && csr_addr == A_MINSTRETH) minstret_d[63:32] = wdata;
    else if (instr_retire && !ir_q)               minstret_d        = minstret_q + 64'd1;
    if (csr_write && csr_addr == A_MCOUNTINHIBIT) begin
      cy_d = wdata[0];
      ir_d = wdata[2];
    end
  end

  // counter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      cy_q       <= 1'b0;
      ir_q       <= 1'b0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      cy_q       <= cy_d;
      ir_q       <= ir_d;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

  // mip assembly from the last synchroniser stage
  always_comb begin
    irq_sync = sync_q[SYNC_STAGES-1];
    mip      = '0;
    mip[3]   = irq_sync[0];
    mip[7]   = irq_sync[1];
    mip[11]  = irq_sync[2];
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip[16+i] = irq_sync[3+i];
  end

  // combinational read mux and SET/CLEAR operand merge
  always_comb begin
    rd_data = '0;
    case (csr_addr)
      A_MSTATUS:  rd_data = {19'b0, mst_mpp_q, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
      A_MISA:     rd_data = misa_q;
      A_MIE:      rd_data = mie_q;
      A_MTVEC:    rd_data = {mtvec_base_q, mtvec_mode_q};
      A_MSTATUSH: rd_data = mstatush_q;
      A_MSCRATCH: rd_data = mscratch_q;
      A_MEPC:     rd_data = mepc_q;
      A_MCAUSE:   rd_data = mcause_q;
      A_MTVAL:    rd_data = mtval_q;
      A_MIP:      rd_data = mip;
      A_MHARTID:  rd_data = HART_ID;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE:        rd_data = mcycle_q[31:0];
      A_MCYCLEH:       rd_data = mcycle_q[63:32];
      A_MINSTRET:      rd_data = minstret_q[31:0];
      A_MINSTRETH:     rd_data = minstret_q[63:32];
      A_MCOUNTINHIBIT: rd_data = {29'b0, ir_q, 1'b0, cy_q};
`endif
      default:    rd_data = '0;
    endcase
    case (csr_op)
      OP_SET:   wdata = rd_data | csr_wr_data;
      OP_CLEAR: wdata = rd_data & ~csr_wr_data;
      default:  wdata = csr_wr_data;
    endcase
  end

  // next state: CSR write first, then trap entry/return override it
  always_comb begin
    mst_mie_d    = mst_mie_q;
    mst_mpie_d   = mst_mpie_q;
    mst_mpp_d    = mst_mpp_q;
    misa_d       = misa_q;
    mstatush_d   = mstatush_q;
    mscratch_d   = mscratch_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mtval_d      = mtval_q;
    mie_d        = mie_q;
    mtvec_base_d = mtvec_base_q;
    mtvec_mode_d = mtvec_mode_q;
    if (csr_write) begin
      case (csr_addr)
        A_MSTATUS: begin
          mst_mie_d  = wdata[3];
          mst_mpie_d = wdata[7];
          mst_mpp_d  = wdata[12:11];
        end
        A_MISA:     misa_d     = wdata;
        A_MSTATUSH: mstatush_d = wdata;
        A_MSCRATCH: mscratch_d = wdata;
        A_MEPC:     mepc_d     = {wdata[31:2], 2'b00};
        A_MCAUSE:   mcause_d   = wdata;
        A_MTVAL:    mtval_d    = wdata;
        A_MIE:      mie_d      = wdata & MIE_MASK;
        A_MTVEC: begin
          mtvec_base_d = wdata[31:2];
          // reserved modes 10/11 leave MODE alone
          if (!wdata[1]) mtvec_mode_d = (wdata[0] && VECTORED_EN) ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
    if (trap_start) begin
      mst_mie_d  = 1'b0;
      mst_mpie_d = mst_mie_q;
      mst_mpp_d  = 2'b11;
      mepc_d     = pc;
      mcause_d   = trap_cause;
      if (!trap_cause[31]) begin
        case (trap_cause)
          CAUSE_BREAK:          mtval_d = pc;
          CAUSE_ILLEGAL:        mtval_d = instruction;
          CAUSE_INST_MISALIGN,
          CAUSE_LOAD_MISALIGN,
          CAUSE_STORE_MISALIGN: mtval_d = misaligned_addr;
          default: ;
        endcase
      end
    end else if (trap_finish) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b0;
      mst_mpp_d  = 2'b00;
    end
    sync_d[0] = irq_raw;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
  end

  // CSR and synchroniser state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie_q    <= 1'b0;
      mst_mpie_q   <= 1'b0;
      mst_mpp_q    <= 2'b00;
      misa_q       <= 32'h4000_0100;
      mstatush_q   <= '0;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mie_q        <= '0;
      mtvec_base_q <= '0;
      mtvec_mode_q <= 2'b00;
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      mst_mie_q    <= mst_mie_d;
      mst_mpie_q   <= mst_mpie_d;
      mst_mpp_q    <= mst_mpp_d;
      misa_q       <= misa_d;
      mstatush_q   <= mstatush_d;
      mscratch_q   <= mscratch_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mtval_q      <= mtval_d;
      mie_q        <= mie_d;
      mtvec_base_q <= mtvec_base_d;
      mtvec_mode_q <= mtvec_mode_d;
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
    end
  end

  // fixed priority MEI > MSI > MTI > local, highest local index wins
  always_comb begin
    irq_act  = mip & mie_q;
    irq_code = 5'd0;
    if (irq_act[11])     irq_code = 5'd11;
    else if (irq_act[3]) irq_code = 5'd3;
    else if (irq_act[7]) irq_code = 5'd7;
    else begin
      for (int i = 0; i < NUM_LOCAL_IRQ; i++)
        if (irq_act[16+i]) irq_code = 5'(16 + i);
    end
    irq_cause   = (|irq_act) ? {1'b1, 26'b0, irq_code} : 32'h0;
    irq_pending = mst_mie_q & (|irq_act);
    mtvec_base  = {mtvec_base_q, 2'b00};
    trap_vector = (mtvec_mode_q == 2'b01 && irq_pending) ?
                  mtvec_base + {25'b0, irq_cause[4:0], 2'b00} : mtvec_base;
  end

  assign csr_rd_data        = rd_data;
  assign interrupted_pc     = mepc_q;
  assign interrupts_enabled = mst_mie_q;
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed vector table plus hand sequences for irq latency, priority, traps and counters
// latency: expectations assume SYNC_STAGES=2 and HART_ID=5
// backpressure: not applicable
module tb_csr_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_write;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wr_data, csr_rd_data;
  logic [31:0] pc, instruction, misaligned_addr, trap_cause;
  logic        trap_start, trap_finish, instr_retire;
  logic        irq_software, irq_timer, irq_external;
  logic [3:0]  irq_local;
  logic [31:0] trap_vector, interrupted_pc, irq_cause;
  logic        irq_pending, interrupts_enabled;

  localparam logic [1:0] OP_W = 2'b01, OP_S = 2'b10, OP_C = 2'b11;

  typedef struct {
    logic        wr;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csr_file #(.NUM_LOCAL_IRQ(4), .SYNC_STAGES(2), .VECTORED_EN(1'b1), .HART_ID(32'd5)) dut (
    .clk(clk), .rst_n(rst_n), .csr_write(csr_write), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data), .pc(pc), .instruction(instruction),
    .misaligned_addr(misaligned_addr), .trap_start(trap_start), .trap_finish(trap_finish),
    .trap_cause(trap_cause), .instr_retire(instr_retire), .irq_software(irq_software),
    .irq_timer(irq_timer), .irq_external(irq_external), .irq_local(irq_local),
    .trap_vector(trap_vector), .interrupted_pc(interrupted_pc), .irq_pending(irq_pending),
    .irq_cause(irq_cause), .interrupts_enabled(interrupts_enabled)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(name, csr_rd_data, exp);
  endtask

  // call at a negedge: the write is committed by the following rising edge
  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_write   = 1'b1;
    csr_op      = op;
    csr_addr    = a;
    csr_wr_data = d;
    @(negedge clk);
    csr_write   = 1'b0;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic retire_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      instr_retire = 1'b1;
      @(negedge clk);
      instr_retire = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; csr_write = 1'b0; csr_op = OP_W; csr_addr = '0; csr_wr_data = '0;
    pc = '0; instruction = '0; misaligned_addr = '0; trap_cause = '0;
    trap_start = 1'b0; trap_finish = 1'b0; instr_retire = 1'b0;
    irq_software = 1'b0; irq_timer = 1'b0; irq_external = 1'b0; irq_local = 4'h0;

    // ---- reset, including a reset that lands on an in-flight write
    #23 rst_n = 1'b1;
    @(negedge clk);
    wr(OP_W, 12'h340, 32'h0000_0055);
    rd_check("mscratch_pre", 12'h340, 32'h0000_0055);
    @(negedge clk);
    csr_write = 1'b1; csr_op = OP_W; csr_addr = 12'h340; csr_wr_data = 32'h0000_00AA;
    #2 rst_n = 1'b0;
    @(negedge clk);
    csr_write = 1'b0;
    rst_n = 1'b1;
    rd_check("rst_mscratch", 12'h340, 32'h0);
    rd_check("rst_mstatus", 12'h300, 32'h0);
    rd_check("rst_misa", 12'h301, 32'h4000_0100);
    @(negedge clk);
    rd_check("rst_mhartid", 12'hF14, 32'd5);
    check("rst_irq_pending", {31'b0, irq_pending}, 32'h0);
    check("rst_irq_cause", irq_cause, 32'h0);
    check("rst_trap_vector", trap_vector, 32'h0);
    check("rst_interrupted_pc", interrupted_pc, 32'h0);
    check("rst_int_en", {31'b0, interrupts_enabled}, 32'h0);
    @(negedge clk);

    // ---- register access table
    vecs.push_back('{1'b1, OP_W, 12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, OP_S, 12'h340, 32'h0000_00F0, 32'hDEAD_BEFF});
    vecs.push_back('{1'b1, OP_C, 12'h340, 32'hDEAD_0000, 32'h0000_BEFF});
    vecs.push_back('{1'b1, 2'b00, 12'h340, 32'h1234_5678, 32'h1234_5678});
    vecs.push_back('{1'b1, OP_W, 12'hF11, 32'h0000_1234, 32'h0});
    vecs.push_back('{1'b1, OP_W, 12'h7C0, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b1, OP_W, 12'h341, 32'h0000_1237, 32'h0000_1234});
    vecs.push_back('{1'b1, OP_W, 12'h304, 32'hFFFF_FFFF, 32'h000F_0888});
    vecs.push_back('{1'b1, OP_C, 12'h304, 32'h0000_0008, 32'h000F_0880});
    vecs.push_back('{1'b1, OP_W, 12'h305, 32'h0000_0103, 32'h0000_0100});
    vecs.push_back('{1'b1, OP_W, 12'h305, 32'h0000_0101, 32'h0000_0101});
    vecs.push_back('{1'b1, OP_W, 12'h305, 32'h0000_0402, 32'h0000_0401});
    vecs.push_back('{1'b1, OP_W, 12'h342, 32'h8000_000B, 32'h8000_000B});
    vecs.push_back('{1'b1, OP_W, 12'h344, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b1, OP_W, 12'h310, 32'h5A5A_5A5A, 32'h5A5A_5A5A});
    vecs.push_back('{1'b0, OP_W, 12'hF14, 32'h0, 32'd5});
    vecs.push_back('{1'b1, OP_W, 12'hF14, 32'hFFFF_FFFF, 32'd5});
    vecs.push_back('{1'b1, OP_W, 12'h300, 32'hFFFF_FFFF, 32'h0000_1888});
    vecs.push_back('{1'b1, OP_W, 12'h300, 32'h0, 32'h0});
    vecs.push_back('{1'b1, OP_W, 12'h343, 32'h0000_0011, 32'h0000_0011});
`ifdef CSR_COUNTERS_EN
    vecs.push_back('{1'b1, OP_W, 12'h320, 32'hFFFF_FFFF, 32'h0000_0005});
    vecs.push_back('{1'b1, OP_W, 12'h320, 32'h0, 32'h0});
`else
    vecs.push_back('{1'b1, OP_W, 12'h320, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b1, OP_W, 12'hB00, 32'h0000_0123, 32'h0});
    vecs.push_back('{1'b1, OP_W, 12'hB80, 32'h0000_0123, 32'h0});
    vecs.push_back('{1'b1, OP_W, 12'hB02, 32'h0000_0123, 32'h0});
    vecs.push_back('{1'b1, OP_W, 12'hB82, 32'h0000_0123, 32'h0});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) wr(vecs[i].op, vecs[i].addr, vecs[i].wdat);
      rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      @(negedge clk);
    end

    // ---- vectored interrupt with two-stage synchroniser latency
    wr(OP_W, 12'h305, 32'h0000_1001);
    wr(OP_W, 12'h304, 32'h0000_0800);
    wr(OP_W, 12'h300, 32'h0000_0008);
    irq_external = 1'b1;
    @(negedge clk);
    check("irq_after_1_edge", {31'b0, irq_pending}, 32'h0);
    @(negedge clk);
    check("irq_after_2_edges", {31'b0, irq_pending}, 32'h1);
    check("irq_cause_mei", irq_cause, 32'h8000_000B);
    check("vec_trap_vector", trap_vector, 32'h0000_102C);
    wr(OP_W, 12'h305, 32'h0000_2003);
    rd_check("mtvec_mode11_keep", 12'h305, 32'h0000_2001);
    check("vec_trap_vector2", trap_vector, 32'h0000_202C);
    @(negedge clk);
    irq_external = 1'b0;
    @(negedge clk);
    check("irq_drop_1_edge", {31'b0, irq_pending}, 32'h1);
    @(negedge clk);
    check("irq_drop_2_edges", {31'b0, irq_pending}, 32'h0);
    check("idle_trap_vector", trap_vector, 32'h0000_2000);

    // ---- priority
    wr(OP_W, 12'h304, 32'h0003_0888);
    irq_software = 1'b1; irq_timer = 1'b1; irq_external = 1'b1; irq_local = 4'hF;
    edges(2);
    check("prio_all", irq_cause, 32'h8000_000B);
    irq_external = 1'b0;
    edges(2);
    check("prio_msi", irq_cause, 32'h8000_0003);
    irq_software = 1'b0;
    edges(2);
    check("prio_mti", irq_cause, 32'h8000_0007);
    irq_timer = 1'b0;
    edges(2);
    check("prio_local1", irq_cause, 32'h8000_0011);
    check("prio_local1_vec", trap_vector, 32'h0000_2044);
    rd_check("mip_locals", 12'h344, 32'h000F_0000);
    @(negedge clk);
    irq_local = 4'h0;
    edges(2);
    check("prio_none", irq_cause, 32'h0);
    wr(OP_W, 12'h300, 32'h0);
    check("mie_off_pending", {31'b0, irq_pending}, 32'h0);

    // ---- trap entry and return
    wr(OP_W, 12'h300, 32'h0000_0008);
    trap_start = 1'b1; trap_cause = 32'd2; pc = 32'h200; instruction = 32'hFFFF_FFFF;
    @(negedge clk);
    trap_start = 1'b0;
    rd_check("trap_mepc", 12'h341, 32'h0000_0200);
    rd_check("trap_mtval", 12'h343, 32'hFFFF_FFFF);
    rd_check("trap_mstatus", 12'h300, 32'h0000_1880);
    check("trap_int_en", {31'b0, interrupts_enabled}, 32'h0);
    check("trap_interrupted_pc", interrupted_pc, 32'h0000_0200);
    @(negedge clk);
    trap_finish = 1'b1;
    @(negedge clk);
    trap_finish = 1'b0;
    rd_check("mret_mstatus", 12'h300, 32'h0000_0008);
    @(negedge clk);

    // ---- simultaneous events
    trap_start = 1'b1; trap_cause = 32'h8000_000B; pc = 32'h300;
    csr_write = 1'b1; csr_op = OP_W; csr_addr = 12'h300; csr_wr_data = 32'h0;
    @(negedge clk);
    trap_start = 1'b0; csr_write = 1'b0;
    rd_check("sim_wr_mstatus", 12'h300, 32'h0000_1880);
    rd_check("irq_trap_mtval", 12'h343, 32'hFFFF_FFFF);
    rd_check("irq_trap_mcause", 12'h342, 32'h8000_000B);
    @(negedge clk);
    trap_start = 1'b1; trap_finish = 1'b1; trap_cause = 32'd3; pc = 32'h400;
    @(negedge clk);
    trap_start = 1'b0; trap_finish = 1'b0;
    rd_check("sim_fin_mstatus", 12'h300, 32'h0000_1800);
    rd_check("break_mtval", 12'h343, 32'h0000_0400);
    rd_check("break_mepc", 12'h341, 32'h0000_0400);
    @(negedge clk);
    trap_start = 1'b1; trap_cause = 32'd4; misaligned_addr = 32'h0000_0ABD;
    @(negedge clk);
    trap_start = 1'b0;
    rd_check("misalign_mtval", 12'h343, 32'h0000_0ABD);
    @(negedge clk);

`ifdef CSR_COUNTERS_EN
    // ---- counters
    wr(OP_W, 12'hB00, 32'hFFFF_FFFF);
    wr(OP_W, 12'hB80, 32'hFFFF_FFFF);
    @(negedge clk);
    rd_check("mcycle_wrap_lo", 12'hB00, 32'h0);
    rd_check("mcycle_wrap_hi", 12'hB80, 32'h0);
    @(negedge clk);
    wr(OP_W, 12'h320, 32'h0000_0001);
    wr(OP_W, 12'hB00, 32'h0000_0010);
    edges(3);
    rd_check("mcycle_inhibit", 12'hB00, 32'h0000_0010);
    @(negedge clk);
    wr(OP_S, 12'h320, 32'h0000_0004);
    retire_pulses(3);
    rd_check("minstret_inhibit", 12'hB02, 32'h0);
    @(negedge clk);
    wr(OP_C, 12'h320, 32'h0000_0004);
    retire_pulses(3);
    rd_check("minstret_count", 12'hB02, 32'h3);
    rd_check("minstreth_count", 12'hB82, 32'h0);
    @(negedge clk);
`else
    retire_pulses(2);
    rd_check("no_ctr_minstret", 12'hB02, 32'h0);
    rd_check("no_ctr_mcycle", 12'hB00, 32'h0);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
